// File: rtl/sym_fir_interpolator_if.sv
// Streaming bus for sym_fir_interpolator: input sample handshake plus
// output sample handshake. The slave modport is the filter's view; the
// master modport is the view of whoever feeds and drains it.
interface sym_fir_interpolator_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 24
);
  logic signed [IN_W-1:0]  data_in;
  logic                    valid_in;
  logic                    ready_out;
  logic signed [OUT_W-1:0] data_out;
  logic                    valid_out;
  logic                    ready_in;

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out
  );

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out
  );
endinterface

// File: rtl/sym_fir_interpolator.sv
// Polyphase interpolating FIR with a symmetric impulse response.
// Each accepted sample produces INTERP outputs, one per phase; the
// zero-stuffed samples are implied by the phase and never stored.
// Optional feature: define SYM_FIR_INTERP_FLUSH_EN to add a flush_in port
// that clears the filter exactly like rst and wins over an input handshake.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no output pending (valid_out=0), ready for a new sample
// RUN   | data_out holds phase r_phase of the most recent sample
module sym_fir_interpolator #(
  parameter int INPUT_WORD_SIZE = 16,
  parameter int COEFF_WORD_SIZE = 5,
  parameter int N_COEFFS        = 3,
  parameter logic [N_COEFFS*COEFF_WORD_SIZE-1:0] COEFFS = 15'h0C41,
  parameter int INTERP          = 2
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef SYM_FIR_INTERP_FLUSH_EN
  input  logic                   flush_in,
`endif
  sym_fir_interpolator_if.slave  bus
);

  localparam int OUTPUT_WORD_SIZE = INPUT_WORD_SIZE + COEFF_WORD_SIZE + $clog2(N_COEFFS) + 1;
  localparam int NTAPS = 2 * N_COEFFS - 1;
  localparam int DEPTH = (2 * N_COEFFS - 2) / INTERP + 1;
  localparam int PW    = $clog2(INTERP);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [INPUT_WORD_SIZE-1:0]  r_dline      [DEPTH];
  logic signed [INPUT_WORD_SIZE-1:0]  w_shift_line [DEPTH];
  logic signed [INPUT_WORD_SIZE-1:0]  w_sel_line   [DEPTH];
  logic signed [OUTPUT_WORD_SIZE-1:0] w_phase_sum  [INTERP];
  logic signed [OUTPUT_WORD_SIZE-1:0] w_next_sum;
  logic signed [OUTPUT_WORD_SIZE-1:0] r_data_out;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_sel_phase;

  logic w_clear;
  logic w_valid_out;
  logic w_ready_out;
  logic w_last;
  logic w_in_hs;
  logic w_out_hs;

  // Symmetric tap lookup: h[j] mirrors around the centre coefficient.
  function automatic logic signed [OUTPUT_WORD_SIZE-1:0] tap_coef(input int j);
    int idx;
    logic [COEFF_WORD_SIZE-1:0] c;
    idx = (j < NTAPS - 1 - j) ? j : NTAPS - 1 - j;
    c   = COEFFS[idx*COEFF_WORD_SIZE +: COEFF_WORD_SIZE];
    return {{(OUTPUT_WORD_SIZE-COEFF_WORD_SIZE){c[COEFF_WORD_SIZE-1]}}, c};
  endfunction

  function automatic logic signed [OUTPUT_WORD_SIZE-1:0] sext_in(
    input logic [INPUT_WORD_SIZE-1:0] x);
    return {{(OUTPUT_WORD_SIZE-INPUT_WORD_SIZE){x[INPUT_WORD_SIZE-1]}}, x};
  endfunction

`ifdef SYM_FIR_INTERP_FLUSH_EN
  assign w_clear = rst | flush_in;
`else
  assign w_clear = rst;
`endif

  assign w_last   = (r_phase == PW'(INTERP - 1));
  assign w_in_hs  = bus.valid_in & w_ready_out;
  assign w_out_hs = w_valid_out & bus.ready_in;

  assign bus.data_out  = r_data_out;
  assign bus.valid_out = w_valid_out;
  assign bus.ready_out = w_ready_out;

  // State register.
  always_ff @(posedge clk) begin
    if (w_clear) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic: a new sample always (re)starts RUN, so a last-phase
  // handshake coinciding with an input keeps streaming without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_in_hs) w_state_nxt = S_RUN;
      S_RUN:   if (w_out_hs && w_last && !w_in_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: input is only taken when the current burst is finishing.
  always_comb begin
    w_valid_out = (r_state == S_RUN);
    w_ready_out = !w_valid_out || (bus.ready_in && w_last);
  end

  // Candidate delay line (after a shift) and the line/phase feeding the MAC.
  always_comb begin
    w_shift_line[0] = bus.data_in;
    for (int i = 1; i < DEPTH; i++) w_shift_line[i] = r_dline[i-1];
    for (int i = 0; i < DEPTH; i++) w_sel_line[i] = w_in_hs ? w_shift_line[i] : r_dline[i];
    w_sel_phase = w_in_hs ? '0 : r_phase + PW'(1);
  end

  // Per-phase sums; tap j belongs to phase j mod INTERP and multiplies the
  // sample (j - p) / INTERP positions back in the stored history.
  always_comb begin
    for (int p = 0; p < INTERP; p++) begin
      w_phase_sum[p] = '0;
      for (int j = 0; j < NTAPS; j++) begin
        if (j % INTERP == p)
          w_phase_sum[p] = w_phase_sum[p] + sext_in(w_sel_line[(j - p) / INTERP]) * tap_coef(j);
      end
    end
  end

  // Phase mux, written as a compare loop so non-power-of-two INTERP is safe.
  always_comb begin
    w_next_sum = '0;
    for (int p = 0; p < INTERP; p++) begin
      if (PW'(p) == w_sel_phase) w_next_sum = w_phase_sum[p];
    end
  end

  // Datapath: shift on input, step phase on a non-final output handshake,
  // otherwise hold (covers both the stall and the end-of-burst cases).
  always_ff @(posedge clk) begin
    if (w_clear) begin
      for (int i = 0; i < DEPTH; i++) r_dline[i] <= '0;
      r_phase    <= '0;
      r_data_out <= '0;
    end else if (w_in_hs) begin
      for (int i = 0; i < DEPTH; i++) r_dline[i] <= w_shift_line[i];
      r_phase    <= '0;
      r_data_out <= w_next_sum;
    end else if (w_out_hs && !w_last) begin
      r_phase    <= r_phase + PW'(1);
      r_data_out <= w_next_sum;
    end
  end

endmodule

// File: tb/tb_sym_fir_interpolator.sv
// Directed bench for sym_fir_interpolator: default coefficients {1,2,3}
// with L=2 on dut_a, and an all-15 coefficient set on dut_b for the
// full-scale negative input case.
module tb_sym_fir_interpolator;
  localparam int IN_W  = 16;
  localparam int OUT_W = 24;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef SYM_FIR_INTERP_FLUSH_EN
  logic flush_a;
  logic flush_b;
`endif

  always #5 clk = ~clk;

  sym_fir_interpolator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) if_a ();
  sym_fir_interpolator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) if_b ();

  sym_fir_interpolator dut_a (
    .clk      (clk),
    .rst      (rst),
`ifdef SYM_FIR_INTERP_FLUSH_EN
    .flush_in (flush_a),
`endif
    .bus      (if_a)
  );

  sym_fir_interpolator #(.COEFFS({5'd15, 5'd15, 5'd15})) dut_b (
    .clk      (clk),
    .rst      (rst),
`ifdef SYM_FIR_INTERP_FLUSH_EN
    .flush_in (flush_b),
`endif
    .bus      (if_b)
  );

  task automatic check_val(input string tag, input logic signed [31:0] act,
                           input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_a.valid_in = 1'b0; if_a.data_in = '0; if_a.ready_in = 1'b1;
    if_b.valid_in = 1'b0; if_b.data_in = '0; if_b.ready_in = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int exp_imp[6]  = '{100, 200, 300, 200, 100, 0};
  int exp_ten[8]  = '{10, 20, 40, 40, 50, 40, 50, 40};
  int exp_max[6]  = '{-491520, -491520, -983040, -983040, -1474560, -983040};

  initial begin
`ifdef SYM_FIR_INTERP_FLUSH_EN
    flush_a = 1'b0;
    flush_b = 1'b0;
`endif
    // Reset state, including ready_out while rst is still high.
    rst = 1'b1;
    if_a.valid_in = 1'b0; if_a.data_in = '0; if_a.ready_in = 1'b1;
    if_b.valid_in = 1'b0; if_b.data_in = '0; if_b.ready_in = 1'b1;
    step();
    check_val("rst_ready_during", 32'(if_a.ready_out), 1);
    check_val("rst_valid_during", 32'(if_a.valid_out), 0);
    do_reset();
    check_val("rst_valid", 32'(if_a.valid_out), 0);
    check_val("rst_data", $signed(if_a.data_out), 0);
    check_val("rst_ready", 32'(if_a.ready_out), 1);

    // Impulse response: 100 followed by zeros.
    if_a.valid_in = 1'b1; if_a.data_in = 16'sd100;
    for (int i = 0; i < 6; i++) begin
      step();
      if_a.data_in = '0;
      check_val($sformatf("imp_data%0d", i), $signed(if_a.data_out), exp_imp[i]);
      check_val($sformatf("imp_ready%0d", i), 32'(if_a.ready_out), (i % 2 == 1) ? 1 : 0);
    end
    if_a.valid_in = 1'b0;
    step();
    check_val("imp_drain_valid", 32'(if_a.valid_out), 0);
    check_val("imp_drain_hold", $signed(if_a.data_out), 0);

    // Constant input 10: ramps up, then alternates 50/40 with no bubbles.
    do_reset();
    if_a.valid_in = 1'b1; if_a.data_in = 16'sd10;
    for (int i = 0; i < 8; i++) begin
      step();
      check_val($sformatf("const_data%0d", i), $signed(if_a.data_out), exp_ten[i]);
      check_val($sformatf("const_valid%0d", i), 32'(if_a.valid_out), 1);
      check_val($sformatf("const_ready%0d", i), 32'(if_a.ready_out), (i % 2 == 1) ? 1 : 0);
    end

    // Backpressure: freeze at phase 0; a bogus 99 must not be taken.
    step();
    check_val("stall_pre", $signed(if_a.data_out), 50);
    if_a.ready_in = 1'b0; if_a.data_in = 16'sd99;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val($sformatf("stall_data%0d", i), $signed(if_a.data_out), 50);
      check_val($sformatf("stall_ready%0d", i), 32'(if_a.ready_out), 0);
      check_val($sformatf("stall_valid%0d", i), 32'(if_a.valid_out), 1);
    end
    if_a.ready_in = 1'b1; if_a.data_in = 16'sd10;
    step();
    check_val("stall_resume_ph1", $signed(if_a.data_out), 40);
    step();
    check_val("stall_resume_ph0", $signed(if_a.data_out), 50);
    if_a.valid_in = 1'b0;

    // Reset mid-burst: remaining phase dropped, history cleared.
    do_reset();
    if_a.valid_in = 1'b1; if_a.data_in = 16'sd100;
    step();
    check_val("mid_first", $signed(if_a.data_out), 100);
    rst = 1'b1; if_a.valid_in = 1'b0;
    step();
    check_val("mid_valid", 32'(if_a.valid_out), 0);
    check_val("mid_data", $signed(if_a.data_out), 0);
    check_val("mid_ready", 32'(if_a.ready_out), 1);
    rst = 1'b0;
    if_a.valid_in = 1'b1; if_a.data_in = 16'sd7;
    step();
    if_a.valid_in = 1'b0;
    check_val("mid_ph0", $signed(if_a.data_out), 7);
    step();
    check_val("mid_ph1", $signed(if_a.data_out), 14);
    step();
    check_val("mid_end_valid", 32'(if_a.valid_out), 0);

    // Full-scale negative input with all coefficients at 15.
    do_reset();
    if_b.valid_in = 1'b1; if_b.data_in = -16'sd32768;
    for (int i = 0; i < 6; i++) begin
      step();
      check_val($sformatf("max_data%0d", i), $signed(if_b.data_out), exp_max[i]);
    end
    if_b.valid_in = 1'b0;

`ifdef SYM_FIR_INTERP_FLUSH_EN
    // Flush together with a valid input: input dropped, history zeroed.
    do_reset();
    if_a.valid_in = 1'b1; if_a.data_in = 16'sd100;
    step();
    if_a.valid_in = 1'b0;
    check_val("fl_ph0", $signed(if_a.data_out), 100);
    step();
    check_val("fl_ph1", $signed(if_a.data_out), 200);
    flush_a = 1'b1; if_a.valid_in = 1'b1; if_a.data_in = 16'sd55;
    step();
    flush_a = 1'b0; if_a.valid_in = 1'b0;
    check_val("fl_valid", 32'(if_a.valid_out), 0);
    check_val("fl_data", $signed(if_a.data_out), 0);
    if_a.valid_in = 1'b1; if_a.data_in = 16'sd7;
    step();
    if_a.valid_in = 1'b0;
    check_val("fl_after_ph0", $signed(if_a.data_out), 7);
    step();
    check_val("fl_after_ph1", $signed(if_a.data_out), 14);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sym_fir_interpolator.md
SYM_FIR_INTERPOLATOR -- requirements
Module: sym_fir_interpolator

Interface
REQ-001 SHALL have parameter INPUT_WORD_SIZE, default 16: signed input sample width.
REQ-002 SHALL have parameter COEFF_WORD_SIZE, default 5: signed coefficient width.
REQ-003 SHALL have parameter N_COEFFS, default 3: unique coefficients C[0..N-1]; C[N-1] is the centre tap.
REQ-004 SHALL have parameter COEFFS, default 15'h0C41: packed signed coefficients, C[i] = COEFFS[i*COEFF_WORD_SIZE +: COEFF_WORD_SIZE].
REQ-005 SHALL have parameter INTERP, default 2: upsampling factor L, legal range 2..8.
REQ-006 SHALL use localparam OUTPUT_WORD_SIZE = INPUT_WORD_SIZE + COEFF_WORD_SIZE + clog2(N_COEFFS) + 1.
REQ-007 clk  input  1  single clock; all logic on the rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 data_in  input  INPUT_WORD_SIZE  signed input sample.
REQ-010 valid_in  input  1  data_in valid.
REQ-011 ready_out  output  1  block accepts data_in this cycle.
REQ-012 data_out  output  OUTPUT_WORD_SIZE  signed interpolated sample, registered.
REQ-013 valid_out  output  1  data_out valid.
REQ-014 ready_in  input  1  downstream accepts data_out this cycle.

Function
REQ-015 SHALL compute y[n] = sum over j = 0..2N-2 of h[j]*u[n-j], with h[j] = C[min(j, 2N-2-j)] and u[n] = x[k] if n = k*L, else 0.
REQ-016 SHALL hold the last floor((2N-2)/L)+1 accepted samples in a delay line; zero-stuffed samples are never stored.
REQ-017 Output phase p (0..L-1) SHALL sum the taps j with j mod L == p, multiplied by the stored sample x[k-(j-p)/L].
REQ-018 Products and sums SHALL be signed and sign-extended to OUTPUT_WORD_SIZE before addition; no rounding, truncation or saturation.
REQ-019 Input handshake SHALL occur when valid_in && ready_out; output handshake SHALL occur when valid_out && ready_in.
REQ-020 ready_out SHALL equal !valid_out || (ready_in && phase == L-1); it is combinational.
REQ-021 On input handshake: shift the delay line, set phase to 0, register the phase-0 result, and set valid_out to 1 on the next edge (latency 1 cycle).
REQ-022 On output handshake with phase < L-1: increment phase and register the next phase result on the same edge.
REQ-023 On output handshake with phase == L-1 and no simultaneous input handshake: clear valid_out; data_out holds its value.
REQ-024 A simultaneous last-phase output handshake and input handshake SHALL both complete with no bubble, giving sustained throughput of one output per cycle.
REQ-025 While valid_out && !ready_in, data_out, phase and the delay line SHALL remain stable.
REQ-026 State machine: IDLE (valid_out=0) -> RUN on input handshake; RUN -> IDLE on last-phase output handshake without input; RUN -> RUN otherwise.

Reset
REQ-027 While rst is high on a clock edge: the delay line is cleared to zeros, phase is 0, data_out is 0, valid_out is 0, and the state is IDLE.
REQ-028 Reset asserted mid-burst SHALL abandon the remaining phases; the first output after reset SHALL use an all-zero history.
REQ-029 ready_out SHALL be 1 during and after reset (valid_out = 0).

Configuration
REQ-030 When macro SYM_FIR_INTERP_FLUSH_EN is defined, the block SHALL add input flush_in (1 bit).
REQ-031 With SYM_FIR_INTERP_FLUSH_EN defined, flush_in high on an edge SHALL zero the delay line, phase, data_out and valid_out, identical to rst, and SHALL override a simultaneous input handshake.
REQ-032 Without SYM_FIR_INTERP_FLUSH_EN, no flush_in port or logic SHALL exist, and behaviour is otherwise identical.

Verification
REQ-033 Defaults, ready_in=1, single input 100 then continuous zeros -> data_out sequence 100,200,300,200,100,0 on consecutive cycles.
REQ-034 Defaults, continuous input of constant 10 -> steady-state outputs alternate 50,40 (phase0 = C0+C2+C0, phase1 = C1+C1), scaled by 10; ready_out stays 1 on every second cycle with no bubbles.
REQ-035 ready_in held low for 5 cycles while valid_out=1 -> data_out and phase frozen, ready_out=0, and no input accepted.
REQ-036 rst pulsed after the phase-0 output of input 100 -> valid_out=0 next cycle; next input 7 gives outputs 7,14, with no residue from 100.
REQ-037 Input -32768 (INPUT_WORD_SIZE=16), C=all 15 (COEFF_WORD_SIZE=5) -> exact signed result with no overflow at OUTPUT_WORD_SIZE.
REQ-038 With SYM_FIR_INTERP_FLUSH_EN defined, flush_in asserted together with valid_in -> input is dropped, valid_out=0, and the delay line is zeroed.
